// File: rtl/dp_row_psum_collector_pkg.sv
// Shared types, lane geometry and the saturating lane adder for the row psum collector.
package dp_pkg;

  localparam int M          = 4;
  localparam int PSUM_BW    = 20;
  localparam int ACC_BW     = 24;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int PSUM_VEC_W = M * PSUM_BW;
  localparam int ACC_VEC_W  = M * ACC_BW;

  typedef enum logic {IDLE, ACCUM} collect_state_t;

  typedef struct packed {
    logic              sat;
    logic [ACC_BW-1:0] val;
  } sat_res_t;

  // One extra bit of headroom makes overflow visible as a mismatch of the two top bits.
  function automatic sat_res_t sat_add(input logic [ACC_BW-1:0] acc, input logic [PSUM_BW-1:0] psum);
    logic [ACC_BW:0] sum;
    sat_res_t        res;
    sum = {acc[ACC_BW-1], acc} + {{(ACC_BW + 1 - PSUM_BW){psum[PSUM_BW-1]}}, psum};
    if (sum[ACC_BW] != sum[ACC_BW-1]) begin
      res.sat = 1'b1;
      res.val = sum[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
    end else begin
      res.sat = 1'b0;
      res.val = sum[ACC_BW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_row_psum_collector_fifo.sv
// Registered result-vector FIFO: power-of-two depth, wrapping pointers, head read combinationally.
module dp_psum_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign push_ok_s = push_i && (count_q != CW'(DEPTH));
  assign pop_ok_s  = pop_i && (count_q != {CW{1'b0}});
  assign data_o    = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != {CW{1'b0}});
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = push_ok_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dp_row_psum_collector.sv
// Accumulates M-lane psums over tile passes and queues finished vectors for the writer.
// Optional build macro DP_COLLECT_RELU_EN clamps negative lanes to zero at push time.
module dp_row_psum_collector
  import dp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [PSUM_VEC_W-1:0] psum_in,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [ACC_VEC_W-1:0]  out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  sat_flag
);

  collect_state_t       state_q, state_d;
  logic [ACC_BW-1:0]    acc_q [M];
  logic [ACC_BW-1:0]    acc_d [M];
  logic                 sat_q, sat_d;
  sat_res_t             lane_res_s [M];
  logic                 accept_s, push_s, pop_s;
  logic [ACC_VEC_W-1:0] push_data_s;

  // Readiness depends only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready = (fifo_count < CNT_W'(DEPTH));
  assign accept_s = in_valid && in_ready;
  assign pop_s    = out_valid && out_ready;
  assign sat_flag = sat_q;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      lane_res_s[i] = sat_add((state_q == ACCUM) ? acc_q[i] : {ACC_BW{1'b0}},
                              psum_in[i*PSUM_BW +: PSUM_BW]);
    end
  end

  always_comb begin
    state_d     = state_q;
    sat_d       = sat_q;
    push_s      = 1'b0;
    push_data_s = {ACC_VEC_W{1'b0}};
    for (int i = 0; i < M; i++) acc_d[i] = acc_q[i];
    case (state_q)
      IDLE, ACCUM: begin
        if (accept_s) begin
          state_d = in_last ? IDLE : ACCUM;
          push_s  = in_last;
          for (int i = 0; i < M; i++) begin
            sat_d = sat_d | lane_res_s[i].sat;
            if (in_last) begin
              acc_d[i] = {ACC_BW{1'b0}};
`ifdef DP_COLLECT_RELU_EN
              push_data_s[i*ACC_BW +: ACC_BW] = lane_res_s[i].val[ACC_BW-1] ?
                                                {ACC_BW{1'b0}} : lane_res_s[i].val;
`else
              push_data_s[i*ACC_BW +: ACC_BW] = lane_res_s[i].val;
`endif
            end else begin
              acc_d[i] = lane_res_s[i].val;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sat_q   <= 1'b0;
      for (int i = 0; i < M; i++) acc_q[i] <= {ACC_BW{1'b0}};
    end else begin
      state_q <= state_d;
      sat_q   <= sat_d;
      for (int i = 0; i < M; i++) acc_q[i] <= acc_d[i];
    end
  end

  dp_psum_fifo #(
    .WIDTH (ACC_VEC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push_s),
    .data_i  (push_data_s),
    .pop_i   (pop_s),
    .data_o  (out_data),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_dp_row_psum_collector.sv
// Directed bench for dp_row_psum_collector with a queue-based reference model and literal pins.
module tb_dp_row_psum_collector;

  localparam int M     = 4;
  localparam int PB    = 20;
  localparam int AB    = 24;
  localparam int DEPTH = 4;
  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_last;
  logic [79:0]  psum_in;
  logic         in_ready;
  logic         out_valid;
  logic [95:0]  out_data;
  logic         out_ready;
  logic [2:0]   fifo_count;
  logic         sat_flag;

  int vectors = 0;
  int errors  = 0;

  logic [95:0] mq [$];
  longint      macc [M];
  bit          mpart;
  bit          msat;

  dp_row_psum_collector dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .psum_in    (psum_in),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] lane(input logic [95:0] v, input int i);
    return v[i*AB +: AB];
  endfunction

  function automatic logic [79:0] pk(input longint l0, input longint l1, input longint l2, input longint l3);
    return {l3[19:0], l2[19:0], l1[19:0], l0[19:0]};
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < M; i++) macc[i] = 0;
    mpart = 1'b0;
    msat  = 1'b0;
  endtask

  // One clock: drive inputs, predict handshakes from model occupancy, then commit the model after the edge.
  task automatic cyc(input logic v, input logic l, input logic [79:0] pin, input logic ordy);
    bit          pop_m, acc_m;
    logic [95:0] pv;
    longint      p, s;
    in_valid  = v;
    in_last   = l;
    psum_in   = pin;
    out_ready = ordy;
    pop_m = reset && (mq.size() != 0) && ordy;
    acc_m = reset && v && (mq.size() < DEPTH);
    @(posedge clk);
    if (pop_m) void'(mq.pop_front());
    if (acc_m) begin
      pv = '0;
      for (int i = 0; i < M; i++) begin
        p = longint'($signed(pin[i*PB +: PB]));
        s = (mpart ? macc[i] : 0) + p;
        if (s > MAXV) begin
          s = MAXV; msat = 1'b1;
        end else if (s < MINV) begin
          s = MINV; msat = 1'b1;
        end
        if (l) begin
`ifdef DP_COLLECT_RELU_EN
          if (s < 0) s = 0;
`endif
          pv[i*AB +: AB] = s[23:0];
          macc[i] = 0;
        end else begin
          macc[i] = s;
        end
      end
      mpart = !l;
      if (l) mq.push_back(pv);
    end
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid",  96'(out_valid),  96'(mq.size() != 0));
      chk("fifo_count", 96'(fifo_count), 96'(mq.size()));
      chk("in_ready",   96'(in_ready),   96'(mq.size() < DEPTH));
      chk("sat_flag",   96'(sat_flag),   96'(msat));
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
    end
  end

  initial begin
    logic [23:0] exp24;
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    psum_in   = pk(3, 0, 0, 0);
    out_ready = 1'b0;
    model_clear();

    // Reset with a valid beat held on the input
    cyc(1'b1, 1'b1, pk(3, 0, 0, 0), 1'b0);
    cyc(1'b1, 1'b1, pk(3, 0, 0, 0), 1'b0);
    chk("t1_count", 96'(fifo_count), 96'd0);
    chk("t1_valid", 96'(out_valid), 96'd0);
    chk("t1_ready", 96'(in_ready), 96'd1);
    reset = 1'b1;

    // Three-pass accumulation then a fresh single-pass vector
    cyc(1'b1, 1'b0, pk(5, 1, -1, 0), 1'b1);
    cyc(1'b1, 1'b0, pk(-2, 2, -3, 0), 1'b1);
    cyc(1'b1, 1'b1, pk(10, 3, -5, 7), 1'b1);
    chk("t2_lane0", 96'(lane(out_data, 0)), 96'd13);
    chk("t2_lane2", 96'(lane(out_data, 2)), 96'(24'hFFFFF7));
    cyc(1'b1, 1'b1, pk(7, 0, 0, 0), 1'b1);
    chk("t2_fresh", 96'(lane(out_data, 0)), 96'd7);
    cyc(1'b0, 1'b0, pk(0, 0, 0, 0), 1'b1);

    // Positive saturation on lane 1, then a negative result on lane 2
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0, pk(0, 524287, 0, 0), 1'b1);
    cyc(1'b1, 1'b1, pk(0, 524287, 0, 0), 1'b1);
    chk("t3_sat_lane1", 96'(lane(out_data, 1)), 96'd8388607);
    chk("t3_sat_flag", 96'(sat_flag), 96'd1);
    cyc(1'b1, 1'b1, pk(0, 0, -40, 0), 1'b1);
`ifdef DP_COLLECT_RELU_EN
    exp24 = 24'd0;
`else
    exp24 = 24'hFFFFD8;
`endif
    chk("t3_neg_lane2", 96'(lane(out_data, 2)), 96'(exp24));
    cyc(1'b0, 1'b0, pk(0, 0, 0, 0), 1'b1);

    // Fill under backpressure, try one extra beat, then drain in order
    for (int k = 1; k <= DEPTH; k++) cyc(1'b1, 1'b1, pk(k, 0, 0, 0), 1'b0);
    chk("t4_full_ready", 96'(in_ready), 96'd0);
    chk("t4_full_count", 96'(fifo_count), 96'd4);
    cyc(1'b1, 1'b1, pk(99, 0, 0, 0), 1'b0);
    chk("t4_reject_count", 96'(fifo_count), 96'd4);
    for (int k = 1; k <= DEPTH; k++) begin
      chk("t4_drain", 96'(lane(out_data, 0)), 96'(k));
      cyc(1'b0, 1'b0, pk(0, 0, 0, 0), 1'b1);
    end
    chk("t4_empty", 96'(out_valid), 96'd0);

    // Steady push+pop at occupancy 2 across several pointer wraps
    cyc(1'b1, 1'b1, pk(100, 0, 0, 0), 1'b0);
    cyc(1'b1, 1'b1, pk(101, 0, 0, 0), 1'b0);
    for (int j = 0; j < 3 * DEPTH; j++) begin
      cyc(1'b1, 1'b1, pk(102 + j, j, -j, 2 * j), 1'b1);
      chk("t5_count", 96'(fifo_count), 96'd2);
    end
    chk("t5_head", 96'(lane(out_data, 0)), 96'd112);
    cyc(1'b0, 1'b0, pk(0, 0, 0, 0), 1'b1);
    cyc(1'b0, 1'b0, pk(0, 0, 0, 0), 1'b1);
    chk("t5_drained", 96'(fifo_count), 96'd0);

    // Asynchronous reset while holding a partial sum and two queued vectors
    cyc(1'b1, 1'b1, pk(1, 0, 0, 0), 1'b0);
    cyc(1'b1, 1'b1, pk(2, 0, 0, 0), 1'b0);
    cyc(1'b1, 1'b0, pk(50, 0, 0, 0), 1'b0);
    #1 reset = 1'b0;
    model_clear();
    #1;
    chk("t6_valid", 96'(out_valid), 96'd0);
    chk("t6_count", 96'(fifo_count), 96'd0);
    chk("t6_sat", 96'(sat_flag), 96'd0);
    cyc(1'b0, 1'b0, pk(0, 0, 0, 0), 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b1, pk(9, 0, 0, 0), 1'b1);
    chk("t6_after", 96'(lane(out_data, 0)), 96'd9);
    cyc(1'b0, 1'b0, pk(0, 0, 0, 0), 1'b1);
    cyc(1'b0, 1'b0, pk(0, 0, 0, 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
